rv32i_control_fsm: RTL and testbench



---
 rtl/rv32i_control_fsm_if.sv | 32 +++
 rtl/rv32i_control_fsm.sv | 113 +++++++++++
 tb/tb_rv32i_control_fsm.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/rv32i_control_fsm_if.sv
// +----------------------------------------------------------------------+
// | rv32i_control_fsm_if                                                 |
// | Run/opcode inputs and datapath strobes/status of the control FSM.    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

interface rv32i_control_fsm_if #(
  parameter int CNT_WIDTH = 32
);
  logic                 run;
  logic [6:0]           opcode;
  logic                 regfile_wren;
  logic                 ir_wren;
  logic                 pc_inc;
  logic                 halted;
  logic                 illegal;
  logic [CNT_WIDTH-1:0] retired_count;
  logic [2:0]           state_o;

  modport master (
    input  run, opcode,
    output regfile_wren, ir_wren, pc_inc, halted, illegal, retired_count, state_o
  );

  modport slave (
    output run, opcode,
    input  regfile_wren, ir_wren, pc_inc, halted, illegal, retired_count, state_o
  );
endinterface

`default_nettype wire

// File: rtl/rv32i_control_fsm.sv
// +----------------------------------------------------------------------+
// | rv32i_control_fsm                                                    |
// | Multicycle RV32I control: fetch, IR load, decode, writeback.         |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module rv32i_control_fsm #(
  parameter int MEM_LATENCY = 1,
  parameter int CNT_WIDTH   = 32
) (
  input  wire logic            clk,
  input  wire logic            rst,
  rv32i_control_fsm_if.master  bus
);

  if ((MEM_LATENCY < 1) || (MEM_LATENCY > 15)) begin : g_bad_latency
    $error("rv32i_control_fsm: MEM_LATENCY must be in 1..15");
  end

  localparam logic [6:0] c_OPC_OP     = 7'b0110011;
  localparam logic [6:0] c_OPC_SYSTEM = 7'b1110011;
  localparam logic [3:0] c_LAT_LAST   = 4'(MEM_LATENCY - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_IR_LOAD   = 3'd2,
    S_DECODE    = 3'd3,
    S_WRITEBACK = 3'd4,
    S_HALTED    = 3'd5,
    S_TRAP      = 3'd6
  } state_t;

  state_t               r_state;
  logic [3:0]           r_lat_cnt;
  logic [CNT_WIDTH-1:0] r_retired;
  logic                 r_halted;
  logic                 r_illegal;
  logic                 r_ir_wren;
  logic                 r_pc_inc;
  logic                 r_rf_wren;

  // Strobes are registered alongside the state transition that enters the
  // state they belong to, so each one is a pure function of the current state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_lat_cnt <= 4'd0;
      r_retired <= '0;
      r_halted  <= 1'b0;
      r_illegal <= 1'b0;
      r_ir_wren <= 1'b0;
      r_pc_inc  <= 1'b0;
      r_rf_wren <= 1'b0;
    end else begin
      r_ir_wren <= 1'b0;
      r_pc_inc  <= 1'b0;
      r_rf_wren <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.run) begin
            r_state   <= S_FETCH;
            r_lat_cnt <= 4'd0;
          end
        end
        S_FETCH: begin
          if (r_lat_cnt == c_LAT_LAST) begin
            r_state   <= S_IR_LOAD;
            r_ir_wren <= 1'b1;
            r_pc_inc  <= 1'b1;
            r_lat_cnt <= 4'd0;
          end else begin
            r_lat_cnt <= r_lat_cnt + 4'd1;
          end
        end
        S_IR_LOAD: r_state <= S_DECODE;
        S_DECODE: begin
          // Retirement is counted on entry so the count includes the
          // instruction currently in WRITEBACK.
          if (bus.opcode == c_OPC_OP) begin
            r_state   <= S_WRITEBACK;
            r_rf_wren <= 1'b1;
            r_retired <= r_retired + CNT_WIDTH'(1);
          end else if (bus.opcode == c_OPC_SYSTEM) begin
            r_state  <= S_HALTED;
            r_halted <= 1'b1;
          end else begin
            r_state   <= S_TRAP;
            r_illegal <= 1'b1;
          end
        end
        S_WRITEBACK: begin
          r_lat_cnt <= 4'd0;
          r_state   <= bus.run ? S_FETCH : S_IDLE;
        end
        S_HALTED, S_TRAP: r_state <= r_state;
        default: r_state <= S_TRAP;
      endcase
    end
  end

  assign bus.state_o       = r_state;
  assign bus.ir_wren       = r_ir_wren;
  assign bus.pc_inc        = r_pc_inc;
  assign bus.regfile_wren  = r_rf_wren;
  assign bus.halted        = r_halted;
  assign bus.illegal       = r_illegal;
  assign bus.retired_count = r_retired;

endmodule

`default_nettype wire

// File: tb/tb_rv32i_control_fsm.sv
// +----------------------------------------------------------------------+
// | tb_rv32i_control_fsm                                                 |
// | Directed bench for the control FSM at MEM_LATENCY 1 (a) and 3 (b).   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_rv32i_control_fsm;
  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  rv32i_control_fsm_if #(.CNT_WIDTH(32)) bus_a ();
  rv32i_control_fsm_if #(.CNT_WIDTH(32)) bus_b ();

  rv32i_control_fsm #(.MEM_LATENCY(1), .CNT_WIDTH(32)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  rv32i_control_fsm #(.MEM_LATENCY(3), .CNT_WIDTH(32)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus_a.run = 1'b0; bus_a.opcode = 7'h33;
    bus_b.run = 1'b0; bus_b.opcode = 7'h33;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (bus_a.state_o !== 3'd0) begin n_err++; $display("FAIL reset_state_a: got %0d want 0", bus_a.state_o); end
    n_cmp++; if ({bus_a.ir_wren, bus_a.pc_inc, bus_a.regfile_wren, bus_a.halted, bus_a.illegal} !== 5'b0) begin
      n_err++; $display("FAIL reset_flags_a: got %b want 00000", {bus_a.ir_wren, bus_a.pc_inc, bus_a.regfile_wren, bus_a.halted, bus_a.illegal}); end
    n_cmp++; if (bus_a.retired_count !== 32'd0) begin n_err++; $display("FAIL reset_count_a: got %0d want 0", bus_a.retired_count); end
    n_cmp++; if (bus_b.state_o !== 3'd0) begin n_err++; $display("FAIL reset_state_b: got %0d want 0", bus_b.state_o); end
    // run=0 keeps IDLE
    tick();
    n_cmp++; if (bus_a.state_o !== 3'd0) begin n_err++; $display("FAIL idle_hold: got %0d want 0", bus_a.state_o); end
  endtask

  // Both latencies run OP instructions back to back in lockstep.
  task automatic test_back_to_back();
    logic [2:0] seq_a [4];
    logic [2:0] seq_b [6];
    logic [2:0] ea, eb;
    seq_a = '{3'd1, 3'd2, 3'd3, 3'd4};
    seq_b = '{3'd1, 3'd1, 3'd1, 3'd2, 3'd3, 3'd4};
    do_reset();
    bus_a.run = 1'b1; bus_b.run = 1'b1;
    for (int e = 1; e <= 20; e++) begin
      tick();
      ea = seq_a[(e - 1) % 4];
      eb = seq_b[(e - 1) % 6];
      n_cmp++; if (bus_a.state_o !== ea) begin n_err++; $display("FAIL b2b_state_a e=%0d: got %0d want %0d", e, bus_a.state_o, ea); end
      n_cmp++; if ({bus_a.ir_wren, bus_a.pc_inc, bus_a.regfile_wren} !== {ea == 3'd2, ea == 3'd2, ea == 3'd4}) begin
        n_err++; $display("FAIL b2b_strobes_a e=%0d: got %b want %b", e, {bus_a.ir_wren, bus_a.pc_inc, bus_a.regfile_wren}, {ea == 3'd2, ea == 3'd2, ea == 3'd4}); end
      n_cmp++; if (bus_b.state_o !== eb) begin n_err++; $display("FAIL b2b_state_b e=%0d: got %0d want %0d", e, bus_b.state_o, eb); end
      n_cmp++; if ({bus_b.ir_wren, bus_b.pc_inc, bus_b.regfile_wren} !== {eb == 3'd2, eb == 3'd2, eb == 3'd4}) begin
        n_err++; $display("FAIL b2b_strobes_b e=%0d: got %b want %b", e, {bus_b.ir_wren, bus_b.pc_inc, bus_b.regfile_wren}, {eb == 3'd2, eb == 3'd2, eb == 3'd4}); end
    end
    n_cmp++; if (bus_a.retired_count !== 32'd5) begin n_err++; $display("FAIL b2b_count_a: got %0d want 5", bus_a.retired_count); end
    n_cmp++; if (bus_b.retired_count !== 32'd3) begin n_err++; $display("FAIL b2b_count_b: got %0d want 3", bus_b.retired_count); end
  endtask

  task automatic test_illegal();
    do_reset();
    bus_a.run = 1'b1; bus_a.opcode = 7'h13;
    for (int e = 1; e <= 4; e++) tick();
    n_cmp++; if (bus_a.state_o !== 3'd6) begin n_err++; $display("FAIL illegal_state: got %0d want 6", bus_a.state_o); end
    n_cmp++; if ({bus_a.illegal, bus_a.halted} !== 2'b10) begin n_err++; $display("FAIL illegal_flags: got %b want 10", {bus_a.illegal, bus_a.halted}); end
    for (int i = 0; i < 12; i++) begin
      bus_a.run = i[0];
      tick();
      n_cmp++; if ({bus_a.state_o, bus_a.ir_wren, bus_a.pc_inc, bus_a.regfile_wren} !== {3'd6, 3'b000}) begin
        n_err++; $display("FAIL trap_hold i=%0d: got %b want 110000", i, {bus_a.state_o, bus_a.ir_wren, bus_a.pc_inc, bus_a.regfile_wren}); end
    end
    n_cmp++; if (bus_a.retired_count !== 32'd0) begin n_err++; $display("FAIL trap_count: got %0d want 0", bus_a.retired_count); end
  endtask

  task automatic test_halt();
    do_reset();
    bus_a.run = 1'b1; bus_a.opcode = 7'h33;
    for (int e = 1; e <= 8; e++) tick();
    bus_a.opcode = 7'h73;
    for (int e = 9; e <= 12; e++) tick();
    n_cmp++; if (bus_a.state_o !== 3'd5) begin n_err++; $display("FAIL halt_state: got %0d want 5", bus_a.state_o); end
    n_cmp++; if ({bus_a.halted, bus_a.illegal} !== 2'b10) begin n_err++; $display("FAIL halt_flags: got %b want 10", {bus_a.halted, bus_a.illegal}); end
    n_cmp++; if (bus_a.retired_count !== 32'd2) begin n_err++; $display("FAIL halt_count: got %0d want 2", bus_a.retired_count); end
    for (int i = 0; i < 5; i++) tick();
    n_cmp++; if (bus_a.state_o !== 3'd5) begin n_err++; $display("FAIL halt_hold: got %0d want 5", bus_a.state_o); end
    rst = 1'b1;
    #1;
    n_cmp++; if ({bus_a.state_o, bus_a.halted, bus_a.illegal, bus_a.regfile_wren} !== 6'b0) begin
      n_err++; $display("FAIL halt_rst: got %b want 000000", {bus_a.state_o, bus_a.halted, bus_a.illegal, bus_a.regfile_wren}); end
    n_cmp++; if (bus_a.retired_count !== 32'd0) begin n_err++; $display("FAIL halt_rst_count: got %0d want 0", bus_a.retired_count); end
    tick();
    rst = 1'b0;
  endtask

  task automatic test_run_drop();
    logic [2:0] exp_st [6];
    exp_st = '{3'd2, 3'd3, 3'd4, 3'd0, 3'd0, 3'd1};
    do_reset();
    bus_a.run = 1'b1; bus_a.opcode = 7'h33;
    tick();
    bus_a.run = 1'b0;
    for (int e = 2; e <= 7; e++) begin
      if (e == 7) bus_a.run = 1'b1;
      if (e == 7) begin
        @(posedge clk); #1;
      end else begin
        tick();
      end
      n_cmp++; if (bus_a.state_o !== exp_st[e - 2]) begin n_err++; $display("FAIL rundrop_state e=%0d: got %0d want %0d", e, bus_a.state_o, exp_st[e - 2]); end
    end
    n_cmp++; if (bus_a.retired_count !== 32'd1) begin n_err++; $display("FAIL rundrop_count: got %0d want 1", bus_a.retired_count); end
  endtask

  task automatic test_async_reset();
    int rf_seen;
    do_reset();
    bus_a.run = 1'b1; bus_a.opcode = 7'h33;
    tick();
    tick();
    n_cmp++; if ({bus_a.ir_wren, bus_a.pc_inc} !== 2'b11) begin n_err++; $display("FAIL arst_pre: got %b want 11", {bus_a.ir_wren, bus_a.pc_inc}); end
    #2;
    rst = 1'b1;
    #1;
    n_cmp++; if ({bus_a.state_o, bus_a.ir_wren, bus_a.pc_inc} !== 5'b0) begin
      n_err++; $display("FAIL arst_drop: got %b want 00000", {bus_a.state_o, bus_a.ir_wren, bus_a.pc_inc}); end
    bus_a.run = 1'b0;
    tick();
    rst = 1'b0;
    rf_seen = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bus_a.regfile_wren) rf_seen++;
    end
    n_cmp++; if (rf_seen !== 0) begin n_err++; $display("FAIL arst_no_wb: got %0d want 0", rf_seen); end
    n_cmp++; if (bus_a.retired_count !== 32'd0) begin n_err++; $display("FAIL arst_count: got %0d want 0", bus_a.retired_count); end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    bus_a.run = 1'b0; bus_a.opcode = 7'h33;
    bus_b.run = 1'b0; bus_b.opcode = 7'h33;
    test_reset();
    test_back_to_back();
    test_illegal();
    test_halt();
    test_run_drop();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

`default_nettype wire
